// File: rtl/namuru_pkg.sv
// namuru_pkg: shared constants and state encoding for the correlator accumulation reader
package namuru_pkg;
    localparam logic [31:0] OFF_STATUS   = 32'h380;
    localparam logic [31:0] OFF_NEW_DATA = 32'h384;
    localparam logic [31:0] OFF_I_E      = 32'h10;
    localparam logic [31:0] OFF_Q_E      = 32'h14;
    localparam logic [31:0] OFF_I_P      = 32'h18;
    localparam logic [31:0] OFF_Q_P      = 32'h1C;
    localparam logic [31:0] OFF_I_L      = 32'h20;
    localparam logic [31:0] OFF_Q_L      = 32'h24;
    localparam logic [31:0] OFF_CARR     = 32'h28;
    localparam logic [31:0] OFF_CODE     = 32'h2C;
    localparam logic [31:0] OFF_EPOCH    = 32'h30;
    localparam logic [7:0]  HDR_MAGIC    = 8'hA5;
    localparam logic [31:0] PAD_WORD     = 32'hFFFF_FFFF;
    localparam int          MEAS_WORDS   = 9;
    localparam int          FRAME_WORDS  = MEAS_WORDS + 1;
    localparam int          FIFO_W       = 33;

    typedef enum logic [2:0] {IDLE, RD_STAT, RD_NEW, RD_MEAS, PAD, DONE} state_e;

    // Word index 1 is I_E; the measurement block is contiguous up to EPOCH.
    function automatic logic [31:0] meas_off(input logic [3:0] widx);
        return OFF_I_E + {26'd0, widx - 4'd1, 2'b00};
    endfunction
endpackage

// File: rtl/namuru_fifo.sv
// namuru_fifo: synchronous FIFO of {last, data} words with asynchronous reset
// Ports: clk/rst; push_i writes push_data_i; pop_i consumes head_o;
//        count_o occupancy, empty_o/full_o flags.
module namuru_fifo
    import namuru_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [FIFO_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [FIFO_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [FIFO_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       count_q;
    logic              pop;

    assign pop     = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);

    always_ff @(posedge clk)
        if (push_i) mem_q[wr_q] <= push_data_i;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop};
        end
endmodule

// File: rtl/namuru_accum_reader.sv
// namuru_accum_reader: Wishbone initiator draining correlator channel 0 into a framed stream
// Ports: correlator_clk/correlator_rst; enable gates new frames; accum_int starts a frame;
//        m_wb_* read-only Wishbone master; out_* stream from the FIFO head;
//        frame_count completed frames, timeout_err sticky ack timeout, busy = not idle.
module namuru_accum_reader
    import namuru_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          TIMEOUT    = 64
) (
    input  logic        correlator_clk,
    input  logic        correlator_rst,
    input  logic        enable,
    input  logic        accum_int,
    output logic [31:0] m_wb_adr_o,
    input  logic [31:0] m_wb_dat_i,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic        m_wb_we_o,
    input  logic        m_wb_ack_i,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] frame_count,
    output logic        timeout_err,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_e              state_q, state_d;
    logic                cyc_q;
    logic [31:0]         adr_q;
    logic [CW-1:0]       tmr_q;
    logic [1:0]          status_q;
    logic [3:0]          widx_q;
    logic [15:0]         frame_count_q;
    logic                timeout_err_q;
    logic                ack, tmo, start_rd, push, push_last, pop;
    logic [31:0]         push_data, rd_adr;
    logic [FIFO_W-1:0]   head;
    logic [FW-1:0]       fifo_count;
    logic                fifo_empty, fifo_full;

    assign ack = cyc_q & m_wb_ack_i;
    // Ack in the last allowed cycle wins over the timeout.
    assign tmo = cyc_q & ~m_wb_ack_i & (tmr_q == CW'(TIMEOUT - 1));
    assign pop = ~fifo_empty & out_ready;

    // widx_q counts words pushed in the current frame (header is word 0).
    always_ff @(posedge correlator_clk or posedge correlator_rst)
        if (correlator_rst) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            adr_q         <= '0;
            tmr_q         <= '0;
            status_q      <= '0;
            widx_q        <= '0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_rd) begin
                cyc_q <= 1'b1;
                adr_q <= rd_adr;
                tmr_q <= '0;
            end else if (ack | tmo) cyc_q <= 1'b0;
            else if (cyc_q) tmr_q <= tmr_q + 1'b1;
            if (state_q == RD_STAT && ack) status_q <= m_wb_dat_i[1:0];
            if (state_q == IDLE) widx_q <= '0;
            else if (push) widx_q <= widx_q + 1'b1;
            if (tmo) timeout_err_q <= 1'b1;
            if (state_q == DONE) frame_count_q <= frame_count_q + 1'b1;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && accum_int && fifo_count <= FW'(FIFO_DEPTH - FRAME_WORDS)) state_d = RD_STAT;
            RD_STAT: state_d = tmo ? PAD : ack ? RD_NEW : RD_STAT;
            RD_NEW:  state_d = tmo ? PAD : ack ? (m_wb_dat_i[0] ? RD_MEAS : DONE) : RD_NEW;
            RD_MEAS: state_d = tmo ? PAD : (ack && widx_q == 4'(MEAS_WORDS)) ? DONE : RD_MEAS;
            PAD:     state_d = widx_q == 4'(MEAS_WORDS) ? DONE : PAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A read state with the bus idle always needs its next read; the cycle
    // spent here is the mandatory idle gap after the previous ack.
    always_comb begin
        start_rd  = ~cyc_q & (state_q == RD_STAT || state_q == RD_NEW || state_q == RD_MEAS);
        rd_adr    = BASE_ADR + (state_q == RD_STAT ? OFF_STATUS :
                                state_q == RD_NEW  ? OFF_NEW_DATA : meas_off(widx_q));
        push      = state_q == PAD || (ack && (state_q == RD_NEW || state_q == RD_MEAS));
        push_data = state_q == PAD    ? PAD_WORD :
                    state_q == RD_NEW ? {HDR_MAGIC, frame_count_q[7:0], 13'd0, m_wb_dat_i[0], status_q} :
                                        m_wb_dat_i;
        push_last = state_q == RD_NEW ? ~m_wb_dat_i[0] : widx_q == 4'(MEAS_WORDS);
    end

    namuru_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (correlator_clk),
        .rst         (correlator_rst),
        .push_i      (push & (~fifo_full | pop)),
        .push_data_i ({push_last, push_data}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign m_wb_adr_o  = adr_q;
    assign m_wb_sel_o  = 4'hF;
    assign m_wb_cyc_o  = cyc_q;
    assign m_wb_stb_o  = cyc_q;
    assign m_wb_we_o   = 1'b0;
    assign out_data    = head[31:0];
    assign out_last    = head[32];
    assign out_valid   = ~fifo_empty;
    assign frame_count = frame_count_q;
    assign timeout_err = timeout_err_q;
    assign busy        = state_q != IDLE;
endmodule

// File: doc/namuru_accum_reader.md
Name: namuru_accum_reader

Overview:
Wishbone initiator that drains one correlator channel's accumulation results without CPU involvement. It waits for the correlator's accum_int interrupt, reads the STATUS and NEW_DATA registers over Wishbone, and, if channel 0 has new data, reads all channel-0 measurement registers. Each burst is packed into a framed word stream and buffered in a small FIFO. It sits between the correlator's slave port and a downstream consumer such as a DMA engine or UART packetiser.

Parameters:
BASE_ADR, 32'h0000_0000, byte base address of the correlator slave
FIFO_DEPTH, 16, output FIFO depth in words; power of two, must be >= 10
TIMEOUT, 64, maximum cycles to wait for m_wb_ack_i before a read is aborted

Ports:
correlator_clk  in  1  clock
correlator_rst  in  1  reset, asynchronous, active-high
enable  in  1  when 0, no new frame is started; a frame already in progress completes
accum_int  in  1  level interrupt from the correlator; cleared by the correlator when STATUS is read
m_wb_adr_o  out  32  Wishbone address
m_wb_dat_i  in  32  Wishbone read data
m_wb_sel_o  out  4  constant 4'hF
m_wb_cyc_o  out  1  Wishbone cycle
m_wb_stb_o  out  1  Wishbone strobe
m_wb_we_o  out  1  constant 0 (this block only reads)
m_wb_ack_i  in  1  Wishbone acknowledge
out_data  out  32  stream data (FIFO head)
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  marks the last word of a frame (FIFO head)
frame_count  out  16  number of frames completed; wraps
timeout_err  out  1  sticky flag, set on any ack timeout
busy  out  1  asserted whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous): FSM to IDLE; cyc, stb, we, busy, timeout_err = 0; frame_count = 0; FIFO emptied, so out_valid = 0.
- Address map, applied as BASE_ADR + offset:
  - STATUS 0x380; NEW_DATA 0x384
  - I_E 0x10, Q_E 0x14, I_P 0x18, Q_P 0x1C, I_L 0x20, Q_L 0x24
  - CARR 0x28, CODE 0x2C, EPOCH 0x30
- FSM states: IDLE, RD_STAT, RD_NEW, RD_MEAS, PAD, DONE.
- IDLE -> RD_STAT requires all of: enable = 1, accum_int = 1, and FIFO free slots >= 10. If any condition is false, stay in IDLE. Reading STATUS clears accum_int, so no interrupt is lost while waiting.
- Read cycle rules:
  - In the first cycle of a read, drive address and assert cyc and stb together.
  - Hold address, cyc and stb stable until ack is sampled.
  - On the edge where ack is sampled: capture m_wb_dat_i, and deassert cyc and stb on that same edge.
  - Leave at least 1 idle cycle between reads.
  - The slave returns a read ack 4 cycles after stb rises; the design must tolerate any latency from 1 to TIMEOUT cycles.
- RD_STAT: latch status[1:0] from the read data -> RD_NEW.
- RD_NEW: latch nd0 = dat[0], then push the header word:
  - header = {8'hA5, seq[7:0], 13'b0, nd0, status[1:0]}, where seq = frame_count[7:0]
  - out_last on the header = ~nd0
  - if nd0 = 1 -> RD_MEAS with index 0; if nd0 = 0 -> DONE.
- RD_MEAS: read the 9 measurement registers in address order (I_E first, EPOCH last), pushing each word as it is captured. out_last = 1 on EPOCH only. After index 8 -> DONE.
- DONE: frame_count increments by 1, then -> IDLE. Frame length is therefore 1 or 10 words.
- Timeout:
  - A per-read cycle counter resets whenever a new read starts.
  - If the counter reaches TIMEOUT without ack: drop cyc/stb, set timeout_err, go to PAD.
  - PAD pushes 32'hFFFF_FFFF for every remaining word of the frame, including the header if it has not been pushed yet. A header pad implies a 10-word frame. The final pad word carries out_last = 1. PAD -> DONE.
  - Consumers therefore always see complete frames.
- FIFO:
  - Push and pop in the same cycle are allowed, including when the FIFO is full and out_ready = 1.
  - Overflow is impossible because of the entry check in IDLE.
  - out_data, out_valid and out_last come straight from the FIFO head; a word is consumed when out_valid & out_ready.
- Reset during a bus cycle: cyc and stb drop immediately (asynchronous); any partial frame in the FIFO is discarded.
- frame_count wraps from 16'hFFFF to 0.

Decomposition:
- Package namuru_pkg:
  - register offset constants
  - header magic 8'hA5
  - pad word 32'hFFFF_FFFF
  - MEAS_WORDS = 9
  - FSM state encoding
- Sub-module namuru_fifo: synchronous FIFO, 33 bits wide (data + last), parameter DEPTH.
  - Outputs: count, empty, full.
  - Reset: asynchronous, active-high.

Test Plan:
- Single frame with new data: responder model with 4-cycle ack, STATUS = 2, NEW_DATA = 1, registers = 0x11..0x19.
  - Expect 10 words: header 0xA500_0006, then 0x11..0x19, with last on word 9.
  - Expect frame_count = 1 and no overlapping bus cycles.
- No new data: NEW_DATA = 0, STATUS = 3.
  - Expect a single word 0xA5xx_0003 with last = 1.
  - Expect exactly 2 bus reads.
- Backpressure: out_ready = 0 and FIFO holding 7 words, then accum_int asserts.
  - Expect no stb and busy = 0.
  - After 1 word drains, expect the read sequence to start.
- Timeout: slave never acks the Q_P read, TIMEOUT = 64.
  - Expect cyc to drop 64 cycles after stb, timeout_err = 1.
  - Expect a 10-word frame whose words 4..9 are 0xFFFF_FFFF, with last on word 9.
- Enable low: accum_int high with enable = 0 -> expect no bus activity. Raising enable -> expect a frame to start.
- Asynchronous reset mid-cycle: assert reset during RD_MEAS.
  - Expect cyc, stb, out_valid and frame_count to go to 0 immediately.
  - After release, the next accum_int produces a clean frame with seq = 0.
